// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level detection, enable masking and a
// claim/complete handshake served through a small four-register bus window.
module irq_ctrl #(
  parameter int NrSrc        = 4,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic [DataWidth-1:0]    rdata_o,
  input  logic [NrSrc-1:0]        irq_src_i,
  output logic                    irq_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

  localparam logic [1:0] RegPending = 2'd0;
  localparam logic [1:0] RegEnable  = 2'd1;
  localparam logic [1:0] RegEdge    = 2'd2;
  localparam logic [1:0] RegClaim   = 2'd3;

  state_e                 state_q, state_d;
  logic [NrSrc-1:0]       src_q, src_prev_q;
  logic [NrSrc-1:0]       pending_q, pending_d;
  logic [NrSrc-1:0]       enable_q, enable_d;
  logic [NrSrc-1:0]       edge_q, edge_d;
  logic [4:0]             active_id_q, active_id_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   irq_q, irq_d;

  logic                   rd_s, wr_s;
  logic [1:0]             reg_s;
  logic [NrSrc-1:0]       qual_s;
  logic [NrSrc-1:0]       claim_clr_s;
  logic [4:0]             claim_id_s;
  logic                   claim_go_s;
  logic                   complete_go_s;
  logic                   unused_s;

  assign unused_s = ^{addr_i, wdata_i};

  // Bus decode and lowest-index arbitration among enabled pending sources
  always_comb begin
    rd_s        = req_i & ~we_i;
    wr_s        = req_i & we_i;
    reg_s       = addr_i[3:2];
    qual_s      = pending_q & enable_q;
    claim_id_s  = 5'd0;
    claim_clr_s = '0;
    for (int i = NrSrc - 1; i >= 0; i--) begin
      if (qual_s[i]) begin
        claim_id_s     = 5'(i + 1);
        claim_clr_s    = '0;
        claim_clr_s[i] = 1'b1;
      end else begin
        claim_id_s = claim_id_s;
      end
    end
    claim_go_s    = rd_s && (reg_s == RegClaim) && (state_q == IDLE) && (|qual_s);
    complete_go_s = wr_s && (reg_s == RegClaim) && (state_q == SERVICE) &&
                    (wdata_i[4:0] == active_id_q);
  end

  // Claim/complete FSM next state
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    case (state_q)
      IDLE: begin
        if (claim_go_s) begin
          state_d     = SERVICE;
          active_id_d = claim_id_s;
        end else begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (complete_go_s) begin
          state_d     = IDLE;
          active_id_d = 5'd0;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d     = IDLE;
        active_id_d = 5'd0;
      end
    endcase
  end

  // Register writes, pending update (new edge beats claim-clear), read mux, irq
  always_comb begin
    enable_d = enable_q;
    edge_d   = edge_q;
    if (wr_s && (reg_s == RegEnable)) begin
      enable_d = wdata_i[NrSrc-1:0];
    end else if (wr_s && (reg_s == RegEdge)) begin
      edge_d = wdata_i[NrSrc-1:0];
    end else begin
      enable_d = enable_q;
    end

    pending_d = (edge_q & ((pending_q & ~(claim_go_s ? claim_clr_s : '0)) |
                           (src_q & ~src_prev_q))) |
                (~edge_q & src_q);

    rdata_d = rdata_q;
    if (rd_s) begin
      rdata_d = '0;
      case (reg_s)
        RegPending: rdata_d[NrSrc-1:0] = pending_q;
        RegEnable:  rdata_d[NrSrc-1:0] = enable_q;
        RegEdge:    rdata_d[NrSrc-1:0] = edge_q;
        RegClaim:   rdata_d[4:0]       = claim_go_s ? claim_id_s : 5'd0;
        default:    rdata_d            = '0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end

    irq_d = (state_q == IDLE) && !claim_go_s && (|qual_s);
  end

  // State registers; reset overrides any same-cycle access or source activity
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      src_q       <= '0;
      src_prev_q  <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      edge_q      <= '0;
      active_id_q <= 5'd0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= irq_src_i;
      src_prev_q  <= src_q;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      edge_q      <= edge_d;
      active_id_q <= active_id_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a register-access vector table followed by
// hand-written claim/complete sequences with hand-computed expectations.
module tb_irq_ctrl;

  localparam logic [1:0] R_PEND  = 2'd0;
  localparam logic [1:0] R_EN    = 2'd1;
  localparam logic [1:0] R_EDGE  = 2'd2;
  localparam logic [1:0] R_CLAIM = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [31:0] rdata_o;
  logic [3:0]  irq_src_i = 4'd0;
  logic        irq_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] rd;

  irq_ctrl #(.NrSrc(4), .DataWidth(32), .AddressWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .irq_src_i(irq_src_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  rsel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    irq_src_i = 4'd0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] rsel, input logic [31:0] data);
    req_i = 1'b1; we_i = 1'b1;
    addr_i = 32'h4000_0000 | {28'd0, rsel, 2'b00};
    wdata_i = data;
    step();
    req_i = 1'b0; we_i = 1'b0; wdata_i = 32'd0;
  endtask

  task automatic bus_read(input logic [1:0] rsel, output logic [31:0] data);
    req_i = 1'b1; we_i = 1'b0;
    addr_i = 32'h8000_0010 | {28'd0, rsel, 2'b00};
    step();
    req_i = 1'b0;
    data = rdata_o;
  endtask

  task automatic pulse(input logic [3:0] lines);
    irq_src_i = lines;
    step();
    irq_src_i = 4'd0;
  endtask

  initial begin
    vecs[0]  = '{"wr_en_all",     1'b1, R_EN,    32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[1]  = '{"rd_en_masked",  1'b0, R_EN,    32'h0,         32'hF, 1'b0};
    vecs[2]  = '{"wr_edge_hold",  1'b1, R_EDGE,  32'h5,         32'hF, 1'b0};
    vecs[3]  = '{"rd_edge",       1'b0, R_EDGE,  32'h0,         32'h5, 1'b0};
    vecs[4]  = '{"wr_pend_ro",    1'b1, R_PEND,  32'hF,         32'h5, 1'b0};
    vecs[5]  = '{"rd_pend",       1'b0, R_PEND,  32'h0,         32'h0, 1'b0};
    vecs[6]  = '{"claim_none",    1'b0, R_CLAIM, 32'h0,         32'h0, 1'b0};
    vecs[7]  = '{"complete_idle", 1'b1, R_CLAIM, 32'h1,         32'h0, 1'b0};
    vecs[8]  = '{"claim_none2",   1'b0, R_CLAIM, 32'h0,         32'h0, 1'b0};
    vecs[9]  = '{"rd_en_again",   1'b0, R_EN,    32'h0,         32'hF, 1'b0};
    vecs[10] = '{"wr_en_3",       1'b1, R_EN,    32'h3,         32'hF, 1'b0};
    vecs[11] = '{"rd_en_3",       1'b0, R_EN,    32'h0,         32'h3, 1'b0};

    do_reset();
    check("reset_rdata", rdata_o, 32'h0);
    check("reset_irq", {31'd0, irq_o}, 32'h0);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].we) bus_write(vecs[i].rsel, vecs[i].wdata);
      else            bus_read(vecs[i].rsel, rd);
      check({vecs[i].name, "_rdata"}, rdata_o, vecs[i].exp_rdata);
      check({vecs[i].name, "_irq"}, {31'd0, irq_o}, {31'd0, vecs[i].exp_irq});
    end

    // Edge pulse on timer source, claim, complete
    do_reset();
    bus_write(R_EN, 32'h1);
    bus_write(R_EDGE, 32'h1);
    pulse(4'b0001);
    check("e_irq_p1", {31'd0, irq_o}, 32'h0);
    step();
    check("e_irq_p2", {31'd0, irq_o}, 32'h0);
    step();
    check("e_irq_p3", {31'd0, irq_o}, 32'h1);
    bus_read(R_CLAIM, rd);
    check("e_claim", rd, 32'h1);
    step();
    check("e_irq_after_claim", {31'd0, irq_o}, 32'h0);
    bus_write(R_CLAIM, 32'h1);
    bus_read(R_PEND, rd);
    check("e_pend_cleared", rd, 32'h0);

    // Mismatched complete ignored; edge latched during SERVICE fires after
    do_reset();
    bus_write(R_EN, 32'h1);
    bus_write(R_EDGE, 32'h1);
    pulse(4'b0001);
    step(); step();
    bus_read(R_CLAIM, rd);
    check("m_claim", rd, 32'h1);
    pulse(4'b0001);
    step(); step();
    bus_write(R_CLAIM, 32'h2);
    step();
    check("m_irq_bad_complete", {31'd0, irq_o}, 32'h0);
    bus_read(R_CLAIM, rd);
    check("m_claim_in_service", rd, 32'h0);
    bus_write(R_CLAIM, 32'h1);
    step();
    check("m_irq_after_complete", {31'd0, irq_o}, 32'h1);
    bus_read(R_CLAIM, rd);
    check("m_reclaim", rd, 32'h1);
    bus_write(R_CLAIM, 32'h1);

    // Level sources 2 and 3: lowest wins, level survives claim
    do_reset();
    bus_write(R_EN, 32'hF);
    irq_src_i = 4'b1100;
    step(); step(); step();
    check("l_irq", {31'd0, irq_o}, 32'h1);
    bus_read(R_CLAIM, rd);
    check("l_claim", rd, 32'h3);
    bus_write(R_CLAIM, 32'h3);
    step();
    check("l_irq_again", {31'd0, irq_o}, 32'h1);
    bus_read(R_CLAIM, rd);
    check("l_claim_again", rd, 32'h3);
    bus_write(R_CLAIM, 32'h3);
    irq_src_i = 4'd0;

    // New edge on source 1 coincides with its claim: pending stays set
    do_reset();
    bus_write(R_EN, 32'h2);
    bus_write(R_EDGE, 32'h2);
    pulse(4'b0010);
    step(); step();
    pulse(4'b0010);
    bus_read(R_CLAIM, rd);
    check("c_claim", rd, 32'h2);
    bus_read(R_PEND, rd);
    check("c_pend_set_wins", rd, 32'h2);

    // Disabled source still accumulates pending; enabling raises irq
    do_reset();
    bus_write(R_EDGE, 32'h1);
    pulse(4'b0001);
    step(); step(); step();
    check("d_irq_disabled", {31'd0, irq_o}, 32'h0);
    bus_read(R_PEND, rd);
    check("d_pend", rd, 32'h1);
    bus_write(R_EN, 32'h1);
    step();
    check("d_irq_enabled", {31'd0, irq_o}, 32'h1);

    // Switching latched edge source to level with line low drops pending
    bus_write(R_EDGE, 32'h0);
    step();
    bus_read(R_PEND, rd);
    check("x_pend_dropped", rd, 32'h0);

    // Reset in the middle of SERVICE
    do_reset();
    bus_write(R_EN, 32'h1);
    bus_write(R_EDGE, 32'h1);
    pulse(4'b0001);
    step(); step();
    bus_read(R_CLAIM, rd);
    check("r_claim", rd, 32'h1);
    rst_i = 1'b1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h4; wdata_i = 32'hF;
    irq_src_i = 4'b1111;
    step();
    rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; wdata_i = 32'd0; irq_src_i = 4'd0;
    check("r_rdata", rdata_o, 32'h0);
    check("r_irq", {31'd0, irq_o}, 32'h0);
    bus_read(R_EN, rd);
    check("r_en", rd, 32'h0);
    bus_read(R_EDGE, rd);
    check("r_edge", rd, 32'h0);
    step();
    bus_read(R_PEND, rd);
    check("r_pend", rd, 32'h0);
    bus_read(R_CLAIM, rd);
    check("r_claim_after", rd, 32'h0);
    check("r_irq_after", {31'd0, irq_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NrSrc, default 4, number of interrupt sources (1..31).
REQ-002 SHALL have parameter DataWidth, default 32, bus data width.
REQ-003 SHALL have parameter AddressWidth, default 32, bus address width.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_i  input  1  bus device request.
REQ-007 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port addr_i  input  AddressWidth  byte address; only addr_i[3:2] decoded.
REQ-009 SHALL have port wdata_i  input  DataWidth  write data.
REQ-010 SHALL have port rdata_o  output  DataWidth  read data, registered.
REQ-011 SHALL have port irq_src_i  input  NrSrc  raw interrupt lines; bit 0 connects to the timer.
REQ-012 SHALL have port irq_o  output  1  interrupt request to core_top, registered.

Function
REQ-013 SHALL decode the register map from addr_i[3:2]: 0 PENDING (RO), 1 ENABLE (RW), 2 EDGE (RW, 1 = edge, 0 = level), 3 CLAIM on read / COMPLETE on write.
REQ-014 SHALL register irq_src_i once into src_q; src_q feeds all detection logic.
REQ-015 SHALL, for an edge source, set pending[i] on src_q[i] & ~src_prev[i], where src_prev is src_q delayed one cycle.
REQ-016 SHALL, for a level source, hold pending[i] equal to src_q[i] every cycle, unaffected by claim.
REQ-017 SHALL perform writes in the cycle req_i & we_i is high; bits at and above NrSrc ignored; writes to PENDING ignored.
REQ-018 SHALL present rdata_o one cycle after req_i & ~we_i and hold it until the next read; unused upper bits read 0.
REQ-019 SHALL implement FSM states IDLE and SERVICE; reset state IDLE.
REQ-020 SHALL drive irq_o = 1 in the cycle after any (pending & ENABLE) is nonzero while the FSM is in IDLE, else 0.
REQ-021 SHALL return on a CLAIM read in IDLE: id = (lowest index i with pending[i] & ENABLE[i]) + 1; latch id into active_id; clear pending[i] if edge; go to SERVICE.
REQ-022 SHALL return 0 on a CLAIM read when no source qualifies or the FSM is in SERVICE, with no state change.
REQ-023 SHALL, on a COMPLETE write in SERVICE with wdata_i[4:0] == active_id, clear active_id and return to IDLE next cycle.
REQ-024 SHALL ignore a COMPLETE write with a mismatched id, or any COMPLETE write in IDLE.
REQ-025 SHALL keep pending[i] set when a new edge and a claim-clear of the same source coincide (set wins).
REQ-026 SHALL latch new edges during SERVICE; they assert irq_o after return to IDLE.
REQ-027 SHALL let ENABLE gate only irq_o and claim; pending still accumulates for disabled sources.
REQ-028 SHALL take effect on an EDGE mode change from the next cycle; switching to level drops a latched edge pending when src_q is 0.

Reset
REQ-029 SHALL, while rst_i is high on a clock edge, clear pending, ENABLE, EDGE, src_q, src_prev, active_id, rdata_o and irq_o to 0, and set FSM to IDLE.
REQ-030 SHALL give reset priority over any same-cycle bus access or source edge, including mid-SERVICE.

Verification
REQ-031 SHALL cover: ENABLE = 0x1, EDGE = 0x1, 1-cycle pulse on src 0 -> irq_o = 1 three cycles after the pulse; CLAIM read = 1; irq_o = 0 next cycle; COMPLETE 1 -> IDLE.
REQ-032 SHALL cover: ENABLE = 0xF, level on sources 2 and 3 -> CLAIM = 3; after COMPLETE 3 with source 2 still high -> irq_o = 1 again, CLAIM = 3.
REQ-033 SHALL cover: in SERVICE with active_id = 1, COMPLETE 2 -> ignored, irq_o stays 0; COMPLETE 1 -> IDLE.
REQ-034 SHALL cover: edge on source 1 in the same cycle as CLAIM of source 1 -> PENDING read = 0x2 after the claim.
REQ-035 SHALL cover: ENABLE = 0, edge on source 0 -> irq_o stays 0 and PENDING = 0x1; write ENABLE = 1 -> irq_o = 1 next cycle.
REQ-036 SHALL cover: rst_i pulsed mid-SERVICE -> all registers read 0, irq_o = 0, a CLAIM read returns 0.
